sofeof_axis_tx_buf: RTL and testbench

//  Buffered, frame-checking successor to the SOF/EOF -> AXI-S TX adapter for the Aurora TX port.

---
 rtl/sofeof_axis_tx_buf.sv | 182 ++++++++++++++++++
 tb/tb_sofeof_axis_tx_buf.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sofeof_axis_tx_buf.sv
// SOF/EOF framed word stream to AXI-Stream TX adapter with framing repair, length limit
// and a DEPTH-entry FIFO that decouples upstream TREADY from M_AXI_TX_TREADY.
module sofeof_axis_tx_buf #(
  parameter int AXI_Width = 16,
  parameter int DEPTH     = 16,
  parameter int MAX_WORDS = 256
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     SOF,
  input  logic                     EOF,
  input  logic                     TVALID,
  input  logic [AXI_Width-1:0]     DATA,
  output logic                     TREADY,
  output logic [AXI_Width-1:0]     M_AXI_TX_TDATA,
  output logic                     M_AXI_TX_TVALID,
  output logic                     M_AXI_TX_TLAST,
  input  logic                     M_AXI_TX_TREADY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic [15:0]              FRAMES_SENT,
  output logic                     ERR_ORPHAN,
  output logic                     ERR_NOEOF,
  output logic                     ERR_TRUNC
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INFRM = 2'd1,
    S_FLUSH = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic [AXI_Width:0]   mem_q [DEPTH];
  logic [15:0]          frames_q;
  logic                 err_orphan_q, err_noeof_q, err_trunc_q;
  logic                 err_orphan_d, err_noeof_d, err_trunc_d;

  logic                 full_s, valid_s, sof_hold_s, tready_s, accept_s, rd_en_s;
  logic                 wr_en_s, wr_last_s;
  logic [AXI_Width-1:0] wr_data_s;
  logic [AXI_Width:0]   head_s;

  assign full_s     = (count_q == DEPTH_L);
  assign valid_s    = (count_q != '0);
  // A SOF arriving mid-frame is held off so the terminator can be queued ahead of it.
  assign sof_hold_s = (state_q == S_INFRM) & TVALID & SOF;
  assign tready_s   = ~RST & ~full_s & ~sof_hold_s & (state_q != S_FLUSH);
  assign accept_s   = TVALID & tready_s;
  assign rd_en_s    = valid_s & M_AXI_TX_TREADY;
  assign head_s     = mem_q[rd_ptr_q];

  // Framing FSM: next state, FIFO write request and error pulses.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_en_s      = 1'b0;
    wr_last_s    = 1'b0;
    wr_data_s    = DATA;
    err_orphan_d = 1'b0;
    err_noeof_d  = 1'b0;
    err_trunc_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s & SOF) begin
          wr_en_s   = 1'b1;
          wr_last_s = EOF;
          if (!EOF) begin
            state_d = S_INFRM;
            cnt_d   = CW'(1);
          end else begin
            state_d = S_IDLE;
          end
        end else if (accept_s) begin
          err_orphan_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INFRM: begin
        if (sof_hold_s) begin
          err_noeof_d = 1'b1;
          state_d     = S_FLUSH;
        end else if (accept_s) begin
          wr_en_s = 1'b1;
          if (EOF) begin
            wr_last_s = 1'b1;
            state_d   = S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            wr_last_s   = 1'b1;
            err_trunc_d = 1'b1;
            state_d     = S_DROP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = S_INFRM;
        end
      end
      S_FLUSH: begin
        if (!full_s) begin
          wr_en_s   = 1'b1;
          wr_last_s = 1'b1;
          wr_data_s = '0;
          state_d   = S_IDLE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_DROP: begin
        if (accept_s & SOF) begin
          wr_en_s   = 1'b1;
          wr_last_s = EOF;
          if (EOF) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_INFRM;
            cnt_d   = CW'(1);
          end
        end else if (accept_s & EOF) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DROP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pointers, occupancy, frame counter and error pulse registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frames_q     <= 16'd0;
      err_orphan_q <= 1'b0;
      err_noeof_q  <= 1'b0;
      err_trunc_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_orphan_q <= err_orphan_d;
      err_noeof_q  <= err_noeof_d;
      err_trunc_q  <= err_trunc_d;
      if (wr_en_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en_s, rd_en_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (rd_en_s & head_s[AXI_Width]) frames_q <= frames_q + 16'd1;
    end
  end

  // FIFO storage; contents need no reset because the empty flag masks them.
  always_ff @(posedge CLK) begin
    if (wr_en_s & ~RST) mem_q[wr_ptr_q] <= {wr_last_s, wr_data_s};
  end

  assign TREADY          = tready_s;
  assign M_AXI_TX_TVALID = valid_s;
  assign M_AXI_TX_TDATA  = valid_s ? head_s[AXI_Width-1:0] : '0;
  assign M_AXI_TX_TLAST  = valid_s & head_s[AXI_Width];
  assign LEVEL           = count_q;
  assign FRAMES_SENT     = frames_q;
  assign ERR_ORPHAN      = err_orphan_q;
  assign ERR_NOEOF       = err_noeof_q;
  assign ERR_TRUNC       = err_trunc_q;

endmodule

// File: tb/tb_sofeof_axis_tx_buf.sv
// Directed bench for sofeof_axis_tx_buf (DEPTH=16, MAX_WORDS=4 so truncation is reachable).
module tb_sofeof_axis_tx_buf;

  logic        CLK = 1'b0;
  logic        RST, SOF, EOF, TVALID, mready;
  logic [15:0] DATA;
  logic        TREADY, M_AXI_TX_TVALID, M_AXI_TX_TLAST;
  logic [15:0] M_AXI_TX_TDATA, FRAMES_SENT;
  logic [4:0]  LEVEL;
  logic        ERR_ORPHAN, ERR_NOEOF, ERR_TRUNC;

  int vectors = 0, miscompares = 0;
  int n_orph = 0, n_noeof = 0, n_trunc = 0;
  int exp_frames = 0;
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];

  always #5 CLK = ~CLK;

  sofeof_axis_tx_buf #(.AXI_Width(16), .DEPTH(16), .MAX_WORDS(4)) dut (
    .CLK(CLK), .RST(RST), .SOF(SOF), .EOF(EOF), .TVALID(TVALID), .DATA(DATA),
    .TREADY(TREADY), .M_AXI_TX_TDATA(M_AXI_TX_TDATA), .M_AXI_TX_TVALID(M_AXI_TX_TVALID),
    .M_AXI_TX_TLAST(M_AXI_TX_TLAST), .M_AXI_TX_TREADY(mready), .LEVEL(LEVEL),
    .FRAMES_SENT(FRAMES_SENT), .ERR_ORPHAN(ERR_ORPHAN), .ERR_NOEOF(ERR_NOEOF),
    .ERR_TRUNC(ERR_TRUNC)
  );

  // Output handshakes and error pulses, observed mid-cycle.
  always @(negedge CLK) begin
    if (M_AXI_TX_TVALID && mready) got_q.push_back({M_AXI_TX_TLAST, M_AXI_TX_TDATA});
    if (ERR_ORPHAN) n_orph++;
    if (ERR_NOEOF)  n_noeof++;
    if (ERR_TRUNC)  n_trunc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    n_orph = 0; n_noeof = 0; n_trunc = 0;
  endtask

  // Present one beat from posedge+1 and hold it until accepted.
  task automatic send(input logic s, input logic e, input logic [15:0] d);
    int   guard = 0;
    logic ok;
    SOF = s; EOF = e; DATA = d; TVALID = 1'b1;
    do begin
      @(negedge CLK); ok = TREADY;
      @(posedge CLK); #1;
      guard++;
    end while (!ok && guard < 200);
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: beat %h not accepted, TREADY=%b required 1", d, TREADY);
    end
    TVALID = 1'b0; SOF = 1'b0; EOF = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((LEVEL != 5'd0 || M_AXI_TX_TVALID) && g < 300) begin
      @(posedge CLK); #1; g++;
    end
    if (g >= 300) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: LEVEL=%0d required 0", LEVEL);
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; SOF = 1'b0; EOF = 1'b0; TVALID = 1'b0; DATA = 16'h0000; mready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    vectors++;
    if ({TREADY, M_AXI_TX_TVALID, M_AXI_TX_TLAST, ERR_ORPHAN, ERR_NOEOF, ERR_TRUNC} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b required 000000",
               {TREADY, M_AXI_TX_TVALID, M_AXI_TX_TLAST, ERR_ORPHAN, ERR_NOEOF, ERR_TRUNC});
    end
    vectors++;
    if ({LEVEL, FRAMES_SENT, M_AXI_TX_TDATA} !== 37'd0) begin
      miscompares++;
      $display("FAIL reset_values: LEVEL=%0d FRAMES=%0d TDATA=%h required 0",
               LEVEL, FRAMES_SENT, M_AXI_TX_TDATA);
    end
    RST = 1'b0;
    mready = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_frame();
    clear_obs();
    send(1'b1, 1'b0, 16'hA001);
    vectors++;
    if ({M_AXI_TX_TVALID, M_AXI_TX_TDATA} !== {1'b1, 16'hA001}) begin
      miscompares++;
      $display("FAIL frame_latency: valid=%b data=%h required 1 a001", M_AXI_TX_TVALID, M_AXI_TX_TDATA);
    end
    send(1'b0, 1'b0, 16'hA002);
    send(1'b0, 1'b0, 16'hA003);
    send(1'b0, 1'b1, 16'hA004);
    drain();
    exp_q = '{17'h0A001, 17'h0A002, 17'h0A003, 17'h1A004};
    exp_frames += 1;
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL frame_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL frame_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (FRAMES_SENT !== 16'(exp_frames) || (n_orph + n_noeof + n_trunc) != 0) begin
      miscompares++;
      $display("FAIL frame_stats: FRAMES=%0d errs=%0d required %0d and 0",
               FRAMES_SENT, n_orph + n_noeof + n_trunc, exp_frames);
    end
  endtask

  task automatic test_single_beat();
    clear_obs();
    send(1'b1, 1'b1, 16'h00AA);
    drain();
    exp_frames += 1;
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 17'h100AA) begin
      miscompares++;
      $display("FAIL single_beat: got %0d beats first %h required 1 beat 100aa",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 17'h0);
    end
    vectors++;
    if (FRAMES_SENT !== 16'(exp_frames) || (n_orph + n_noeof + n_trunc) != 0) begin
      miscompares++;
      $display("FAIL single_stats: FRAMES=%0d errs=%0d required %0d and 0",
               FRAMES_SENT, n_orph + n_noeof + n_trunc, exp_frames);
    end
  endtask

  task automatic test_noeof();
    clear_obs();
    send(1'b1, 1'b0, 16'hB000);
    send(1'b0, 1'b0, 16'hB001);
    send(1'b0, 1'b0, 16'hB002);
    send(1'b1, 1'b0, 16'hC000);
    send(1'b0, 1'b1, 16'hC001);
    drain();
    exp_q = '{17'h0B000, 17'h0B001, 17'h0B002, 17'h10000, 17'h0C000, 17'h1C001};
    exp_frames += 2;
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL noeof_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL noeof_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (n_noeof != 1 || n_orph != 0 || n_trunc != 0 || FRAMES_SENT !== 16'(exp_frames)) begin
      miscompares++;
      $display("FAIL noeof_stats: noeof=%0d orph=%0d trunc=%0d FRAMES=%0d required 1 0 0 %0d",
               n_noeof, n_orph, n_trunc, FRAMES_SENT, exp_frames);
    end
  endtask

  task automatic test_trunc();
    clear_obs();
    send(1'b1, 1'b0, 16'hD000);
    for (int i = 1; i < 5; i++) send(1'b0, 1'b0, 16'hD000 + 16'(i));
    send(1'b0, 1'b1, 16'hD005);
    send(1'b1, 1'b0, 16'hE000);
    send(1'b0, 1'b1, 16'hE001);
    drain();
    exp_q = '{17'h0D000, 17'h0D001, 17'h0D002, 17'h1D003, 17'h0E000, 17'h1E001};
    exp_frames += 2;
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL trunc_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL trunc_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (n_trunc != 1 || n_orph != 0 || n_noeof != 0 || FRAMES_SENT !== 16'(exp_frames)) begin
      miscompares++;
      $display("FAIL trunc_stats: trunc=%0d orph=%0d noeof=%0d FRAMES=%0d required 1 0 0 %0d",
               n_trunc, n_orph, n_noeof, FRAMES_SENT, exp_frames);
    end
  endtask

  task automatic test_backpressure();
    clear_obs();
    mready = 1'b0;
    for (int i = 0; i < 16; i++) send(1'b1, 1'b1, 16'hF000 + 16'(i));
    vectors++;
    if (LEVEL !== 5'd16 || TREADY !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full: LEVEL=%0d TREADY=%b required 16 0", LEVEL, TREADY);
    end
    SOF = 1'b1; EOF = 1'b1; DATA = 16'hF010; TVALID = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    vectors++;
    if (LEVEL !== 5'd16 || TREADY !== 1'b0 || got_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_hold: LEVEL=%0d TREADY=%b out=%0d required 16 0 0",
               LEVEL, TREADY, got_q.size());
    end
    mready = 1'b1;
    send(1'b1, 1'b1, 16'hF010);
    drain();
    for (int i = 0; i < 17; i++) exp_q.push_back({1'b1, 16'hF000 + 16'(i)});
    exp_frames += 17;
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL bp_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL bp_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (FRAMES_SENT !== 16'(exp_frames)) begin
      miscompares++;
      $display("FAIL bp_frames: got %0d required %0d", FRAMES_SENT, exp_frames);
    end
  endtask

  task automatic test_orphan();
    clear_obs();
    send(1'b0, 1'b0, 16'h1234);
    vectors++;
    if (LEVEL !== 5'd0) begin
      miscompares++;
      $display("FAIL orphan_level: got %0d required 0", LEVEL);
    end
    drain();
    vectors++;
    if (n_orph != 1 || got_q.size() != 0 || n_noeof != 0 || n_trunc != 0) begin
      miscompares++;
      $display("FAIL orphan_stats: orph=%0d out=%0d noeof=%0d trunc=%0d required 1 0 0 0",
               n_orph, got_q.size(), n_noeof, n_trunc);
    end
  endtask

  task automatic test_reset_midframe();
    clear_obs();
    mready = 1'b0;
    send(1'b1, 1'b0, 16'h6000);
    send(1'b0, 1'b0, 16'h6001);
    vectors++;
    if (LEVEL !== 5'd2) begin
      miscompares++;
      $display("FAIL midrst_pre: LEVEL=%0d required 2", LEVEL);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    vectors++;
    if (LEVEL !== 5'd0 || M_AXI_TX_TVALID !== 1'b0 || FRAMES_SENT !== 16'd0) begin
      miscompares++;
      $display("FAIL midrst_post: LEVEL=%0d TVALID=%b FRAMES=%0d required 0 0 0",
               LEVEL, M_AXI_TX_TVALID, FRAMES_SENT);
    end
    RST = 1'b0;
    mready = 1'b1;
    exp_frames = 1;
    send(1'b1, 1'b1, 16'h7777);
    drain();
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 17'h17777 || n_noeof != 0) begin
      miscompares++;
      $display("FAIL midrst_after: beats=%0d first=%h noeof=%0d required 1 17777 0",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 17'h0, n_noeof);
    end
    vectors++;
    if (FRAMES_SENT !== 16'(exp_frames)) begin
      miscompares++;
      $display("FAIL midrst_frames: got %0d required %0d", FRAMES_SENT, exp_frames);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_single_beat();
    test_noeof();
    test_trunc();
    test_backpressure();
    test_orphan();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
